// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one fifo write port among 4 requesters, with bursts of up to BURST_LEN words.
// Optional per-requester word counters are enabled by defining FIFO_ARB_STATS_EN.
module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN  = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [3:0]                req,
  input  logic [4*DATA_WIDTH-1:0]   req_data,
  output logic [3:0]                gnt,
  input  logic                      fifo_full,
  input  logic                      fifo_wr_err,
  output logic                      fifo_wr_en,
  output logic [DATA_WIDTH-1:0]     fifo_d_in,
  output logic [1:0]                owner,
  output logic                      busy,
  output logic                      err,
  output logic [4*CNT_WIDTH-1:0]    word_cnt
);

  localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_LEN - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [1:0]          r_owner;
  logic [1:0]          w_owner_nxt;
  logic [1:0]          r_last;
  logic [1:0]          w_last_nxt;
  logic [BEAT_W-1:0]   r_beat;
  logic [BEAT_W-1:0]   w_beat_nxt;
  logic                r_err;
  logic [2:0]          w_pick;
  logic [3:0]          w_gnt;
  logic [DATA_WIDTH-1:0] w_d_in;

  // Scan requesters starting just after the last owner; returns {valid, index}.
  function automatic logic [2:0] rr_pick(input logic [3:0] rq, input logic [1:0] lst);
    logic [1:0] idx;
    logic [2:0] res;
    res = 3'b000;
    for (int k = 1; k <= 4; k++) begin
      idx = lst + 2'(k);
      if (!res[2] && rq[idx]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Candidate for the next burst.
  always_comb begin
    w_pick = rr_pick(req, r_last);
  end

  // State register and burst bookkeeping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_owner <= 2'd0;
      r_last  <= 2'd3;
      r_beat  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_last  <= w_last_nxt;
      r_beat  <= w_beat_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_last_nxt  = r_last;
    w_beat_nxt  = r_beat;
    case (r_state)
      ST_IDLE: begin
        if (w_pick[2]) begin
          w_owner_nxt = w_pick[1:0];
          w_beat_nxt  = '0;
          w_state_nxt = ST_BURST;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_BURST: begin
        if (!req[r_owner]) begin
          // Owner withdrew: end the burst without a transfer.
          w_last_nxt  = r_owner;
          w_state_nxt = ST_IDLE;
        end else if (fifo_full) begin
          w_state_nxt = ST_BURST;
        end else if (r_beat == BEAT_LAST) begin
          w_last_nxt  = r_owner;
          w_beat_nxt  = '0;
          w_state_nxt = ST_IDLE;
        end else begin
          w_beat_nxt  = r_beat + BEAT_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Output logic: grant and data follow the owner's request in the same cycle.
  always_comb begin
    w_gnt  = 4'b0000;
    w_d_in = '0;
    if (r_state == ST_BURST) begin
      w_gnt[r_owner] = req[r_owner] & ~fifo_full;
      if (w_gnt[r_owner]) begin
        w_d_in = req_data[int'(r_owner)*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        w_d_in = '0;
      end
    end else begin
      w_gnt = 4'b0000;
    end
  end

  // Sticky write-error flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_err <= 1'b0;
    end else begin
      r_err <= r_err | fifo_wr_err;
    end
  end

  assign gnt        = w_gnt;
  assign fifo_wr_en = |w_gnt;
  assign fifo_d_in  = w_d_in;
  assign owner      = r_owner;
  assign busy       = (r_state == ST_BURST);
  assign err        = r_err;

`ifdef FIFO_ARB_STATS_EN
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  logic [CNT_WIDTH-1:0] r_cnt [4];

  // Saturating per-requester transferred-word counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (w_gnt[i] && (r_cnt[i] != CNT_MAX)) begin
          r_cnt[i] <= r_cnt[i] + CNT_WIDTH'(1);
        end else begin
          r_cnt[i] <= r_cnt[i];
        end
      end
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_cnt
    assign word_cnt[g*CNT_WIDTH +: CNT_WIDTH] = r_cnt[g];
  end
`else
  assign word_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed, scoreboard-driven bench for fifo_wr_arbiter; expected word counts follow FIFO_ARB_STATS_EN.
module tb_fifo_wr_arbiter;

  logic         clk;
  logic         reset_n;
  logic [3:0]   req;
  logic [127:0] req_data;
  logic [3:0]   gnt;
  logic         fifo_full;
  logic         fifo_wr_err;
  logic         fifo_wr_en;
  logic [31:0]  fifo_d_in;
  logic [1:0]   owner;
  logic         busy;
  logic         err;
  logic [63:0]  word_cnt;

  fifo_wr_arbiter #(.DATA_WIDTH(32), .BURST_LEN(4), .CNT_WIDTH(16)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_data(req_data), .gnt(gnt),
    .fifo_full(fifo_full), .fifo_wr_err(fifo_wr_err), .fifo_wr_en(fifo_wr_en),
    .fifo_d_in(fifo_d_in), .owner(owner), .busy(busy), .err(err), .word_cnt(word_cnt)
  );

  typedef struct packed {
    logic [3:0]  g;
    logic [31:0] d;
  } exp_t;

  exp_t        sb[$];
  int          total;
  int          bad;
  logic        exp_err;
  logic [15:0] exp_cnt [4];
  logic [31:0] dat [4];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [1:0] oh2i(input logic [3:0] oh);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++) if (oh[i]) r = 2'(i);
    return r;
  endfunction

  function automatic logic [63:0] exp_wc();
`ifdef FIFO_ARB_STATS_EN
    return {exp_cnt[3], exp_cnt[2], exp_cnt[1], exp_cnt[0]};
`else
    return 64'd0;
`endif
  endfunction

  task automatic push(input logic [1:0] r, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.g = 4'b0001 << r;
      e.d = dat[r];
      sb.push_back(e);
    end
  endtask

  // One clock cycle: check at the falling edge, then step past the next rising edge.
  task automatic cyc(input logic ew, input logic eb);
    exp_t e;
    @(negedge clk);
    chk("wr_en", {63'd0, fifo_wr_en}, {63'd0, ew});
    chk("busy", {63'd0, busy}, {63'd0, eb});
    chk("err", {63'd0, err}, {63'd0, exp_err});
    chk("word_cnt", word_cnt, exp_wc());
    if (ew) begin
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("gnt", {60'd0, gnt}, {60'd0, e.g});
        chk("d_in", {32'd0, fifo_d_in}, {32'd0, e.d});
        chk("owner", {62'd0, owner}, {62'd0, oh2i(e.g)});
        exp_cnt[oh2i(e.g)] = exp_cnt[oh2i(e.g)] + 16'd1;
      end else begin
        chk("sb_underflow", 64'(sb.size()), 64'd1);
      end
    end else begin
      chk("gnt_zero", {60'd0, gnt}, 64'd0);
      chk("d_in_zero", {32'd0, fifo_d_in}, 64'd0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outs();
    chk("rst_gnt", {60'd0, gnt}, 64'd0);
    chk("rst_wr_en", {63'd0, fifo_wr_en}, 64'd0);
    chk("rst_d_in", {32'd0, fifo_d_in}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_owner", {62'd0, owner}, 64'd0);
    chk("rst_err", {63'd0, err}, 64'd0);
    chk("rst_word_cnt", word_cnt, 64'd0);
  endtask

  task automatic do_reset();
    reset_n     = 1'b0;
    req         = 4'b0000;
    fifo_full   = 1'b0;
    fifo_wr_err = 1'b0;
    #1;
    chk_reset_outs();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    sb.delete();
    exp_err = 1'b0;
    for (int i = 0; i < 4; i++) exp_cnt[i] = 16'd0;
  endtask

  task automatic chk_sb_empty(input string tag);
    chk(tag, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    dat[0] = 32'h1111_1111;
    dat[1] = 32'h2222_2222;
    dat[2] = 32'h3333_3333;
    dat[3] = 32'h4444_4444;
    req_data = {dat[3], dat[2], dat[1], dat[0]};
    reset_n = 1'b0;
    req = 4'b0000;
    fifo_full = 1'b0;
    fifo_wr_err = 1'b0;
    exp_err = 1'b0;
    for (int i = 0; i < 4; i++) exp_cnt[i] = 16'd0;
    #2;

    // 1: single requester, 4-word burst, one IDLE gap, then 2 more words
    do_reset();
    req = 4'b0001;
    push(2'd0, 6);
    cyc(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1);
    cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b1);
    req = 4'b0000;
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b0);
    chk_sb_empty("t1_sb_empty");

    // 2: all requesting, owners rotate 0,1,2,3,0 with 4-word bursts
    do_reset();
    req = 4'b1111;
    cyc(1'b0, 1'b0);
    for (int b = 0; b < 5; b++) begin
      push(2'(b % 4), 4);
      for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1);
      if (b == 4) req = 4'b0000;
      cyc(1'b0, 1'b0);
    end
    chk_sb_empty("t2_sb_empty");

    // 3: requester 2 with fifo_full for 3 cycles mid-burst
    do_reset();
    req = 4'b0100;
    push(2'd2, 4);
    cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b1);
    fifo_full = 1'b1;
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1);
    fifo_full = 1'b0;
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b1);
    req = 4'b0000;
    cyc(1'b0, 1'b0);
    chk_sb_empty("t3_sb_empty");

    // 4: req0 drops after 2 words; req1 takes over and is not preempted
    do_reset();
    req = 4'b0011;
    push(2'd0, 2);
    push(2'd1, 4);
    push(2'd0, 1);
    cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b1);
    req = 4'b0010;
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b1);
    req = 4'b0011;
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1);
    cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b1);
    req = 4'b0000;
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b0);
    chk_sb_empty("t4_sb_empty");

    // 5: error pulse, then reset mid-burst clears everything immediately
    do_reset();
    req = 4'b0100;
    fifo_wr_err = 1'b1;
    push(2'd2, 1);
    cyc(1'b0, 1'b0);
    fifo_wr_err = 1'b0;
    exp_err = 1'b1;
    cyc(1'b1, 1'b1);
    reset_n = 1'b0;
    #1;
    chk_reset_outs();
    do_reset();
    req = 4'b0101;
    push(2'd0, 1);
    cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b1);
    req = 4'b0000;
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b0);
    chk_sb_empty("t5_sb_empty");

    // 6: err is sticky across later traffic; word counts track writes
    fifo_wr_err = 1'b1;
    cyc(1'b0, 1'b0);
    fifo_wr_err = 1'b0;
    exp_err = 1'b1;
    req = 4'b1000;
    push(2'd3, 4);
    cyc(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1);
    req = 4'b0000;
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0);
    chk_sb_empty("t6_sb_empty");
`ifdef FIFO_ARB_STATS_EN
    chk("t6_cnt0", {48'd0, word_cnt[15:0]}, 64'd1);
    chk("t6_cnt3", {48'd0, word_cnt[63:48]}, 64'd4);
`else
    chk("t6_cnt_tied", word_cnt, 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
